ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single data RAM port (ram_2) between two requesters: the core load/store path (port 0, "core") and an external loader/debug port (port 1, "ext").
- Sequences every access through a small FSM: arbitrate, issue, respond.
- Gates writes that would be misaligned.
- Drives a stall to the core while the core's access is pending.
- Sits between control/ALU address generation and ram_2.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TW, 4, width of the access-type code (matches ram_type).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- core_req  in  1  core access request; held until core_gnt.
- core_we  in  1  1=store, 0=load.
- core_type  in  TW  byte/half/word code.
- core_sign  in  1  load sign-extend.
- core_addr  in  AW  byte address (ALU_out).
- core_wdata  in  DW  store data (rs2).
- core_gnt  out  1  one-cycle pulse: request accepted, issued this cycle.
- core_rvalid  out  1  one-cycle pulse: response cycle.
- core_rdata  out  DW  load data, valid with core_rvalid.
- core_err  out  1  misaligned flag, valid with core_rvalid.
- core_stall  out  1  core_req & ~core_rvalid.
- ext_req / ext_we / ext_type / ext_sign / ext_addr / ext_wdata  in  same widths as core_*  loader port.
- ext_gnt / ext_rvalid / ext_rdata / ext_err  out  same widths as core_*  loader responses.
- ram_write_en  out  1  to ram_2.
- ram_read_en  out  1  to ram_2.
- ram_type  out  TW  to ram_2.
- ram_sign  out  1  to ram_2.
- ram_addr  out  AW  to ram_2.
- ram_wdata  out  DW  to ram_2.
- ram_rdata  in  DW  ram_2 data_out, valid the cycle after read_en.
- ram_misaligned  in  1  ram_2 combinational misalign flag for current ram_addr/ram_type.

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Reset: state=IDLE, owner=core, last_winner=ext (so core wins first tie).
- All outputs are 0 in IDLE and during reset; stall follows its equation.
- IDLE:
  - If any req, pick winner and latch its we/type/sign/addr/wdata into issue registers; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle):
  - Drive ram_* from the latched registers.
  - ram_read_en = ~we.
  - ram_write_en = we & ~ram_misaligned.
  - Pulse the winner's gnt.
  - Sample ram_misaligned into err_q.
  - Go to RESP.
- RESP (one cycle):
  - Pulse the winner's rvalid; rdata = ram_rdata for loads, 0 for stores; err = err_q.
  - If any req is sampled (the winner may have dropped or reissued), arbitrate and latch as in IDLE, then go to ISSUE. Otherwise go to IDLE.
- Latency: req seen in cycle T → gnt at T+1 → rvalid at T+2. Sustained throughput is one access per 2 cycles.
- Requester inputs are ignored outside arbitration cycles. After gnt, the requester must either deassert req or present its next access by the RESP cycle.
- Ties and fairness are defined under Optional Feature. A single requester is always served regardless of history.
- A misaligned store performs no write; err=1. A misaligned load returns rdata=0, err=1.
- rst asserted in ISSUE or RESP aborts: no rvalid is produced, and the in-flight write is dropped unless it already occurred in ISSUE.
- The non-winning port's gnt, rvalid, rdata and err stay 0 throughout.

Optional Feature:
- Macro RAM_ARB_RR_EN.
- Defined: round-robin. On a tie the port that did not win last wins; last_winner updates in each ISSUE.
- Undefined: fixed priority, core always wins ties; last_winner logic is not built.

Decomposition:
- Shared package/GLOBALS.v:
  - FSM state encodings ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_RESP=2'd2.
  - Port ids ARB_CORE=1'b0, ARB_EXT=1'b1.
  - Reuse the existing RAM type codes.
- One natural sub-module: arb_pick2, the combinational 2-way winner select with last_winner input. Arbitration policy is isolated there.

Test Plan:
- Core load only: core_req=1, we=0, addr=0x10, ram holds 0xDEADBEEF → core_gnt at T+1 with ram_read_en=1 and ram_addr=0x10; core_rvalid at T+2 with rdata=0xDEADBEEF, err=0; ext outputs stay 0.
- Simultaneous requests, both held 8 cycles, RR enabled: grants alternate core, ext, core, ext. RR disabled: all grants go to core, and ext is served only after core_req drops.
- Misaligned store: ext_we=1, type=word, addr=0x6 → ram_write_en=0 in ISSUE; ext_err=1 with ext_rvalid; a later load from 0x4 returns the prior contents unchanged.
- Back-to-back core stores to 0x0, 0x4, 0x8 with req held → gnt at T+1, T+3, T+5; rvalid at T+2, T+4, T+6; core_stall low only in the rvalid cycles.
- rst pulsed in the ISSUE cycle of a load → no rvalid; state=IDLE next cycle; all outputs 0; a following request is served normally with core winning the first tie.
- Idle bus with no requests for 5 cycles → ram_read_en=ram_write_en=0, all gnt/rvalid 0, core_stall=0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the ram_2 port arbiter: FSM states, requester ids and
// the access-type codes understood by ram_2.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    localparam logic ARB_CORE = 1'b0;
    localparam logic ARB_EXT  = 1'b1;

    localparam int RAM_TW = 4;
    localparam logic [RAM_TW-1:0] RAM_TYPE_BYTE = 4'd0;
    localparam logic [RAM_TW-1:0] RAM_TYPE_HALF = 4'd1;
    localparam logic [RAM_TW-1:0] RAM_TYPE_WORD = 4'd2;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way winner select. Fixed core priority by default;
// round-robin on ties when RAM_ARB_RR_EN is defined.
module arb_pick2
    import ram_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_winner_i,
    output logic any_o,
    output logic winner_o
);

    always_comb begin
        any_o    = req0_i | req1_i;
        winner_o = ARB_CORE;
        if (req0_i && req1_i) begin
`ifdef RAM_ARB_RR_EN
            winner_o = ~last_winner_i;
`else
            winner_o = ARB_CORE;
`endif
        end else if (req1_i) begin
            winner_o = ARB_EXT;
        end
    end

`ifndef RAM_ARB_RR_EN
    logic unused_last_winner;
    assign unused_last_winner = last_winner_i;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single ram_2 port between the core load/store path and the
// external loader port via an IDLE/ISSUE/RESP sequence. RAM_ARB_RR_EN selects
// round-robin tie breaking instead of fixed core priority.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [TW-1:0] core_type,
    input  logic          core_sign,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic          core_err,
    output logic          core_stall,

    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [TW-1:0] ext_type,
    input  logic          ext_sign,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_err,

    output logic          ram_write_en,
    output logic          ram_read_en,
    output logic [TW-1:0] ram_type,
    output logic          ram_sign,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_misaligned
);

    arb_state_e    state_q;
    logic          owner_q;
    logic          we_q;
    logic [TW-1:0] type_q;
    logic          sign_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          err_q;

    logic          pick_any;
    logic          pick_win;
    logic          last_winner;

    logic          sel_we;
    logic [TW-1:0] sel_type;
    logic          sel_sign;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          issue_cyc;
    logic          resp_cyc;
    logic [DW-1:0] resp_data;

    arb_pick2 u_pick (
        .req0_i        (core_req),
        .req1_i        (ext_req),
        .last_winner_i (last_winner),
        .any_o         (pick_any),
        .winner_o      (pick_win)
    );

`ifdef RAM_ARB_RR_EN
    logic last_winner_q;

    // Reset to ext so the core wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_q <= ARB_EXT;
        end else if (state_q == ARB_ISSUE) begin
            last_winner_q <= owner_q;
        end
    end

    assign last_winner = last_winner_q;
`else
    assign last_winner = ARB_EXT;
`endif

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        sel_we    = core_we;
        sel_type  = core_type;
        sel_sign  = core_sign;
        sel_addr  = core_addr;
        sel_wdata = core_wdata;
        if (pick_win == ARB_EXT) begin
            sel_we    = ext_we;
            sel_type  = ext_type;
            sel_sign  = ext_sign;
            sel_addr  = ext_addr;
            sel_wdata = ext_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_CORE;
            we_q    <= 1'b0;
            type_q  <= '0;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE, ARB_RESP: begin
                    if (pick_any) begin
                        owner_q <= pick_win;
                        we_q    <= sel_we;
                        type_q  <= sel_type;
                        sign_q  <= sel_sign;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        state_q <= ARB_ISSUE;
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    err_q   <= ram_misaligned;
                    state_q <= ARB_RESP;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // A reset cycle aborts whatever phase is in flight, so outputs are masked by rst.
    assign issue_cyc = (state_q == ARB_ISSUE) && !rst;
    assign resp_cyc  = (state_q == ARB_RESP) && !rst;
    assign resp_data = (!we_q && !err_q) ? ram_rdata : '0;

    always_comb begin
        core_gnt     = 1'b0;
        core_rvalid  = 1'b0;
        core_rdata   = '0;
        core_err     = 1'b0;
        ext_gnt      = 1'b0;
        ext_rvalid   = 1'b0;
        ext_rdata    = '0;
        ext_err      = 1'b0;
        ram_write_en = 1'b0;
        ram_read_en  = 1'b0;
        ram_type     = '0;
        ram_sign     = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        if (issue_cyc) begin
            ram_read_en  = ~we_q;
            ram_write_en = we_q & ~ram_misaligned;
            ram_type     = type_q;
            ram_sign     = sign_q;
            ram_addr     = addr_q;
            ram_wdata    = wdata_q;
            core_gnt     = (owner_q == ARB_CORE);
            ext_gnt      = (owner_q == ARB_EXT);
        end
        if (resp_cyc) begin
            if (owner_q == ARB_CORE) begin
                core_rvalid = 1'b1;
                core_rdata  = resp_data;
                core_err    = err_q;
            end else begin
                ext_rvalid  = 1'b1;
                ext_rdata   = resp_data;
                ext_err     = err_q;
            end
        end
    end

    assign core_stall = core_req & ~core_rvalid;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: drivers push expected responses at grant
// time from a byte-level memory model; a monitor pops and compares on rvalid.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 4;

    logic          clk;
    logic          rst;
    logic          core_req, core_we, core_sign;
    logic [TW-1:0] core_type;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_rvalid, core_err, core_stall;
    logic [DW-1:0] core_rdata;
    logic          ext_req, ext_we, ext_sign;
    logic [TW-1:0] ext_type;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt, ext_rvalid, ext_err;
    logic [DW-1:0] ext_rdata;
    logic          ram_write_en, ram_read_en, ram_sign, ram_misaligned;
    logic [TW-1:0] ram_type;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    ram_arbiter #(.AW(AW), .DW(DW), .TW(TW)) dut (
        .clk            (clk),
        .rst            (rst),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_type      (core_type),
        .core_sign      (core_sign),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_gnt       (core_gnt),
        .core_rvalid    (core_rvalid),
        .core_rdata     (core_rdata),
        .core_err       (core_err),
        .core_stall     (core_stall),
        .ext_req        (ext_req),
        .ext_we         (ext_we),
        .ext_type       (ext_type),
        .ext_sign       (ext_sign),
        .ext_addr       (ext_addr),
        .ext_wdata      (ext_wdata),
        .ext_gnt        (ext_gnt),
        .ext_rvalid     (ext_rvalid),
        .ext_rdata      (ext_rdata),
        .ext_err        (ext_err),
        .ram_write_en   (ram_write_en),
        .ram_read_en    (ram_read_en),
        .ram_type       (ram_type),
        .ram_sign       (ram_sign),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .ram_misaligned (ram_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- ram_2 stand-in (word-organised, registered read) ----------------
    logic [31:0] init_words [64];
    logic [31:0] ram_mem    [64];
    logic        ram_load;
    logic [31:0] ram_rdata_r;

    function automatic logic [31:0] ram_merge(input logic [31:0] old, input logic [3:0] typ,
                                              input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (typ)
            RAM_TYPE_BYTE: r[8*off +: 8] = wd[7:0];
            RAM_TYPE_HALF: r[16*off[1] +: 16] = wd[15:0];
            default:       r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ram_extract(input logic [31:0] w, input logic [3:0] typ,
                                                input logic sgn, input logic [1:0] off);
        logic [31:0] s;
        s = w >> (8*off);
        case (typ)
            RAM_TYPE_BYTE: return sgn ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
            RAM_TYPE_HALF: return sgn ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
            default:       return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= init_words[i];
        end else if (ram_write_en) begin
            ram_mem[ram_addr[7:2]] <= ram_merge(ram_mem[ram_addr[7:2]], ram_type, ram_addr[1:0], ram_wdata);
        end
        if (ram_read_en)
            ram_rdata_r <= ram_extract(ram_mem[ram_addr[7:2]], ram_type, ram_sign, ram_addr[1:0]);
    end

    assign ram_rdata      = ram_rdata_r;
    assign ram_misaligned = (ram_type == RAM_TYPE_HALF && ram_addr[0]) ||
                            (ram_type == RAM_TYPE_WORD && ram_addr[1:0] != 2'b00);

    // ---------------- reference model: flat little-endian byte memory ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t core_q[$];
    exp_t ext_q[$];
    int   gnt_log[$];
    logic [7:0] mem_model [256];

    function automatic logic misaligned_ref(input logic [3:0] typ, input logic [31:0] a);
        return (typ == RAM_TYPE_HALF && a % 2 != 0) || (typ == RAM_TYPE_WORD && a % 4 != 0);
    endfunction

    function automatic exp_t model_access(input logic we, input logic [3:0] typ, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int nb;
        logic [31:0] v;
        logic [7:0] idx;
        e.cyc   = 0;
        e.err   = misaligned_ref(typ, a);
        e.rdata = 32'h0;
        nb = (typ == RAM_TYPE_BYTE) ? 1 : (typ == RAM_TYPE_HALF) ? 2 : 4;
        if (!e.err) begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) begin
                idx = a[7:0] + 8'(i);
                if (we) mem_model[idx] = wd[8*i +: 8];
                else    v[8*i +: 8] = mem_model[idx];
            end
            if (!we) begin
                if (sgn && nb == 1) v = {{24{v[7]}}, v[7:0]};
                if (sgn && nb == 2) v = {{16{v[15]}}, v[15:0]};
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_port(input int p, input logic req, input logic we, input logic [3:0] typ,
                            input logic sgn, input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            core_req = req; core_we = we; core_type = typ; core_sign = sgn; core_addr = a; core_wdata = wd;
        end else begin
            ext_req = req; ext_we = we; ext_type = typ; ext_sign = sgn; ext_addr = a; ext_wdata = wd;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) core_req = 1'b0;
        else        ext_req  = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the rising edge that starts RESP, req still high.
    task automatic access(input int p, input logic we, input logic [3:0] typ, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd, output int gnt_cyc);
        exp_t e;
        logic g;
        logic mis;
        g = 1'b0;
        gnt_cyc = -1;
        set_port(p, 1'b1, we, typ, sgn, a, wd);
        for (int b = 0; b < 100; b++) begin
            @(negedge clk);
            g = (p == 0) ? core_gnt : ext_gnt;
            if (g) break;
        end
        if (!g) begin
            check($sformatf("gnt_timeout_port%0d", p), 160'(g), 160'(1'b1));
            drop(p);
            @(posedge clk); #1;
            return;
        end
        gnt_cyc = cyc;
        mis = misaligned_ref(typ, a);
        check($sformatf("issue_bus_port%0d", p),
              160'({ram_read_en, ram_write_en, ram_type, ram_sign, ram_addr, ram_wdata}),
              160'({~we, we & ~mis, typ, sgn, a, wd}));
        e = model_access(we, typ, sgn, a, wd);
        e.cyc = gnt_cyc;
        if (p == 0) core_q.push_back(e);
        else        ext_q.push_back(e);
        gnt_log.push_back(p);
        @(posedge clk); #1;
    endtask

    task automatic rand_driver(input int p, input int n);
        int g;
        int gap;
        logic we, sgn;
        logic [3:0] typ;
        logic [31:0] a, wd;
        for (int i = 0; i < n; i++) begin
            we  = 1'($urandom_range(0, 1));
            typ = 4'($urandom_range(0, 2));
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom_range(0, 63);
            wd  = $urandom;
            access(p, we, typ, sgn, a, wd, g);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                drop(p);
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        drop(p);
    endtask

    // ---------------- monitor ----------------
    logic [140:0] all_outs;
    assign all_outs = {core_gnt, core_rvalid, core_rdata, core_err, ext_gnt, ext_rvalid, ext_rdata, ext_err,
                       ram_write_en, ram_read_en, ram_type, ram_sign, ram_addr, ram_wdata};

    always @(negedge clk) begin
        exp_t e;
        check("core_stall", 160'(core_stall), 160'(core_req & ~core_rvalid));
        check("gnt_exclusive", 160'(core_gnt & ext_gnt), 160'(0));
        if (core_rvalid) begin
            if (core_q.size() == 0) begin
                check("core_unexpected_rvalid", 160'(core_rvalid), 160'(0));
            end else begin
                e = core_q.pop_front();
                check("core_resp", 160'({core_rdata, core_err}), 160'({e.rdata, e.err}));
                check("core_resp_latency", 160'(cyc), 160'(e.cyc + 1));
            end
        end else begin
            check("core_quiet", 160'({core_rdata, core_err}), 160'(0));
        end
        if (ext_rvalid) begin
            if (ext_q.size() == 0) begin
                check("ext_unexpected_rvalid", 160'(ext_rvalid), 160'(0));
            end else begin
                e = ext_q.pop_front();
                check("ext_resp", 160'({ext_rdata, ext_err}), 160'({e.rdata, e.err}));
                check("ext_resp_latency", 160'(cyc), 160'(e.cyc + 1));
            end
        end else begin
            check("ext_quiet", 160'({ext_rdata, ext_err}), 160'(0));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int g0, g1, g2, start;
        int exp_order[6];
`ifdef RAM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 1, 1, 1};
`endif
        rst = 1'b1;
        ram_load = 1'b1;
        set_port(0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 64; i++) init_words[i] = $urandom;
        init_words[4] = 32'hDEADBEEF;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 4; j++)
                mem_model[8'(4*i + j)] = init_words[i][8*j +: 8];

        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", 160'({all_outs, core_stall}), 160'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ram_load = 1'b0;

        // Idle bus.
        repeat (5) begin
            @(negedge clk);
            check("idle_bus", 160'({all_outs, core_stall}), 160'(0));
        end
        @(posedge clk); #1;

        // Core word load from 0x10 (holds 0xDEADBEEF).
        start = cyc;
        access(0, 1'b0, RAM_TYPE_WORD, 1'b0, 32'h10, 32'h0, g0);
        check("core_load_gnt_latency", 160'(g0 - start), 160'(1));
        drop(0);

        // Misaligned ext word store to 0x6, then reload 0x4.
        access(1, 1'b1, RAM_TYPE_WORD, 1'b0, 32'h6, 32'hA5A5_5A5A, g0);
        drop(1);
        access(1, 1'b0, RAM_TYPE_WORD, 1'b0, 32'h4, 32'h0, g0);
        drop(1);

        // Back-to-back core stores with req held.
        start = cyc;
        access(0, 1'b1, RAM_TYPE_WORD, 1'b0, 32'h0, 32'h1111_1111, g0);
        access(0, 1'b1, RAM_TYPE_WORD, 1'b0, 32'h4, 32'h2222_2222, g1);
        access(0, 1'b1, RAM_TYPE_WORD, 1'b0, 32'h8, 32'h3333_3333, g2);
        drop(0);
        check("b2b_gnt_times", 160'({g0 - start, g1 - start, g2 - start}), 160'({32'd1, 32'd3, 32'd5}));

        // Reset during the ISSUE cycle of a load.
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, RAM_TYPE_WORD, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_issue_outputs", 160'(all_outs), 160'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        drop(0);
        repeat (3) begin
            @(negedge clk);
            check("post_abort_outputs", 160'({all_outs, core_stall}), 160'(0));
        end
        @(posedge clk); #1;

        // Both requesters held from the first cycle after reset.
        gnt_log.delete();
        start = cyc;
        fork
            begin
                int g;
                access(0, 1'b0, RAM_TYPE_WORD, 1'b0, 32'h10, 32'h0, g);
                check("tie_first_core_latency", 160'(g - start), 160'(1));
                access(0, 1'b0, RAM_TYPE_HALF, 1'b1, 32'h12, 32'h0, g);
                access(0, 1'b0, RAM_TYPE_BYTE, 1'b1, 32'h13, 32'h0, g);
                drop(0);
            end
            begin
                int g;
                access(1, 1'b0, RAM_TYPE_WORD, 1'b0, 32'h20, 32'h0, g);
                access(1, 1'b0, RAM_TYPE_HALF, 1'b0, 32'h22, 32'h0, g);
                access(1, 1'b0, RAM_TYPE_BYTE, 1'b0, 32'h21, 32'h0, g);
                drop(1);
            end
        join
        check("tie_grant_count", 160'(gnt_log.size()), 160'(6));
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            check($sformatf("tie_grant_order_%0d", i), 160'(gnt_log[i]), 160'(exp_order[i]));

        // Randomised traffic on both ports.
        fork
            rand_driver(0, 40);
            rand_driver(1, 40);
        join

        repeat (4) @(negedge clk);
        check("drain_core", 160'(core_q.size()), 160'(0));
        check("drain_ext", 160'(ext_q.size()), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
